// File: rtl/mix_columns_if.sv
// mix_columns_if: handshake and data bundle for the mix_columns_iter engine.
// The master side presents a state and takes the result; the slave side is the engine.
// Optional feature macro: MIX_COLUMNS_ROUNDKEY_EN adds the round_key input column set.
interface mix_columns_if #(
    parameter int regSize = 32,
    parameter int vecSize = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            inv;
    logic [vecSize-1:0][regSize-1:0] vect;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
    logic [vecSize-1:0][regSize-1:0] round_key;
`endif
    logic                            out_valid;
    logic                            out_ready;
    logic [vecSize-1:0][regSize-1:0] new_vect;
    logic                            busy;

`ifdef MIX_COLUMNS_ROUNDKEY_EN
    modport master (
        output in_valid, inv, vect, round_key, out_ready,
        input  in_ready, out_valid, new_vect, busy
    );

    modport slave (
        input  in_valid, inv, vect, round_key, out_ready,
        output in_ready, out_valid, new_vect, busy
    );
`else
    modport master (
        output in_valid, inv, vect, out_ready,
        input  in_ready, out_valid, new_vect, busy
    );

    modport slave (
        input  in_valid, inv, vect, out_ready,
        output in_ready, out_valid, new_vect, busy
    );
`endif
endinterface

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns / InvMixColumns engine.
// Accepts a state of vecSize 32-bit columns, transforms LANES columns per
// cycle in a working buffer, then holds the result until the consumer takes it.
// Column byte order: [31:24] is row 0, [7:0] is row 3. GF(2^8) poly is 0x11B.
// Optional feature macro: MIX_COLUMNS_ROUNDKEY_EN fuses AddRoundKey into the
// column write (round_key sampled together with vect on acceptance).
module mix_columns_iter #(
    parameter int regSize = 32,
    parameter int vecSize = 4,
    parameter int LANES   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mix_columns_if.slave bus
);

    // Width of the column index; at least one bit so the register exists.
    localparam int COL_W = (vecSize > 1) ? $clog2(vecSize) : 1;
    // Index of the first column of the final lane group.
    localparam logic [COL_W-1:0] LAST_IDX = COL_W'(vecSize - LANES);
    // Index increment between lane groups.
    localparam logic [COL_W-1:0] LANES_C  = COL_W'(LANES);

    // Parameter legality is enforced at elaboration.
    generate
        if (regSize != 32) begin : g_bad_reg_size
            $error("mix_columns_iter: regSize must be 32");
        end
        if (LANES < 1) begin : g_bad_lanes_min
            $error("mix_columns_iter: LANES must be at least 1");
        end else if ((vecSize % LANES) != 0) begin : g_bad_lanes_div
            $error("mix_columns_iter: LANES must divide vecSize");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef logic [vecSize-1:0][regSize-1:0] vect_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers
    // ------------------------------------------------------------------

    // Multiply by x modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One forward output byte: 2*b0 ^ 3*b1 ^ b2 ^ b3.
    function automatic logic [7:0] fwd_row(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        return xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
    endfunction

    // One inverse output byte: 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3, built from
    // shared doubling chains (x2, x4, x8) of each operand.
    function automatic logic [7:0] inv_row(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] p0_2, p0_4, p0_8;
        logic [7:0] p1_2, p1_8;
        logic [7:0] p2_4, p2_8;
        logic [7:0] p3_8;
        p0_2 = xtime(b0);
        p0_4 = xtime(p0_2);
        p0_8 = xtime(p0_4);
        p1_2 = xtime(b1);
        p1_8 = xtime(xtime(p1_2));
        p2_4 = xtime(xtime(b2));
        p2_8 = xtime(p2_4);
        p3_8 = xtime(xtime(xtime(b3)));
        return (p0_8 ^ p0_4 ^ p0_2)          // 0e * b0
             ^ (p1_8 ^ p1_2 ^ b1)            // 0b * b1
             ^ (p2_8 ^ p2_4 ^ b2)            // 0d * b2
             ^ (p3_8 ^ b3);                  // 09 * b3
    endfunction

    // Full column transform; each row uses the operand list rotated by its row number.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
        logic [7:0]  a0, a1, a2, a3;
        logic [31:0] res;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        if (inv_mode) begin
            res = {inv_row(a0, a1, a2, a3), inv_row(a1, a2, a3, a0),
                   inv_row(a2, a3, a0, a1), inv_row(a3, a0, a1, a2)};
        end else begin
            res = {fwd_row(a0, a1, a2, a3), fwd_row(a1, a2, a3, a0),
                   fwd_row(a2, a3, a0, a1), fwd_row(a3, a0, a1, a2)};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           next_state_s;
    logic [COL_W-1:0] idx_r;
    logic [COL_W-1:0] idx_next_s;
    logic             mode_r;
    vect_t            work_r;
    vect_t            work_next_s;
    vect_t            new_vect_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             accept_s;
    logic             step_s;
    logic             last_s;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
    vect_t            rk_r;
`endif

    // Next-state and sequencing decode for the IDLE/BUSY/DONE controller.
    always_comb begin
        next_state_s = state_r;
        idx_next_s   = idx_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    idx_next_s   = '0;
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step_s = 1'b1;
                if (idx_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    idx_next_s   = '0;
                    next_state_s = ST_DONE;
                end else begin
                    idx_next_s   = idx_r + LANES_C;
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                idx_next_s   = '0;
            end
        endcase
    end

    // Working buffer with the current lane group replaced by its transform.
    always_comb begin
        logic [COL_W-1:0] col_v;
        col_v       = '0;
        work_next_s = work_r;
        for (int l = 0; l < LANES; l++) begin
            col_v = idx_r + COL_W'(l);
`ifdef MIX_COLUMNS_ROUNDKEY_EN
            work_next_s[col_v] = mix_col(work_r[col_v], mode_r) ^ rk_r[col_v];
`else
            work_next_s[col_v] = mix_col(work_r[col_v], mode_r);
`endif
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake and status flags, registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == ST_IDLE);
            out_valid_r <= (next_state_s == ST_DONE);
            busy_r      <= (next_state_s == ST_BUSY);
        end
    end

    // Column index and the mode captured with the accepted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= '0;
            mode_r <= 1'b0;
        end else begin
            idx_r <= idx_next_s;
            if (accept_s) begin
                mode_r <= bus.inv;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Working buffer: loaded on acceptance, updated in place while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= '0;
        end else if (accept_s) begin
            work_r <= bus.vect;
        end else if (step_s) begin
            work_r <= work_next_s;
        end else begin
            work_r <= work_r;
        end
    end

`ifdef MIX_COLUMNS_ROUNDKEY_EN
    // Round key captured alongside the state so later key changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_r <= '0;
        end else if (accept_s) begin
            rk_r <= bus.round_key;
        end else begin
            rk_r <= rk_r;
        end
    end
`endif

    // Result register: takes the completed buffer as the last group is written, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_vect_r <= '0;
        end else if (last_s) begin
            new_vect_r <= work_next_s;
        end else begin
            new_vect_r <= new_vect_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.new_vect  = new_vect_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: self-checking bench for mix_columns_iter.
// Two engines (LANES=1 and LANES=4) share one stimulus stream; a transaction
// level model predicts handshake timing and results for each, and the compare
// task runs on every falling clock edge. Directed literal vectors pin the model.
// Optional feature macro: MIX_COLUMNS_ROUNDKEY_EN.
`timescale 1ns/1ps
module tb_mix_columns_iter;

    localparam int REG = 32;
    localparam int VEC = 4;

    typedef logic [VEC-1:0][REG-1:0] state_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    logic   in_valid;
    logic   inv;
    logic   out_ready;
    state_t vect;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
    state_t round_key;
`endif

    always #5 clk = ~clk;

    mix_columns_if #(.regSize(REG), .vecSize(VEC)) bus_a ();
    mix_columns_if #(.regSize(REG), .vecSize(VEC)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.inv       = inv;
    assign bus_a.vect      = vect;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.inv       = inv;
    assign bus_b.vect      = vect;
    assign bus_b.out_ready = out_ready;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
    assign bus_a.round_key = round_key;
    assign bus_b.round_key = round_key;
`endif

    mix_columns_iter #(.regSize(REG), .vecSize(VEC), .LANES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mix_columns_iter #(.regSize(REG), .vecSize(VEC), .LANES(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic   rdy [2];
    logic   ovl [2];
    logic   bsy [2];
    state_t nv  [2];
    assign rdy[0] = bus_a.in_ready;
    assign rdy[1] = bus_b.in_ready;
    assign ovl[0] = bus_a.out_valid;
    assign ovl[1] = bus_b.out_valid;
    assign bsy[0] = bus_a.busy;
    assign bsy[1] = bus_b.busy;
    assign nv[0]  = bus_a.new_vect;
    assign nv[1]  = bus_b.new_vect;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    bit     inflight [2];
    int     acc      [2];
    state_t exp_v    [2];

    // Cycles from acceptance to out_valid for each engine.
    function automatic int lat_of(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Shift-and-add GF(2^8) multiply, polynomial 0x11B.
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Matrix-times-column over every column, then XOR with the key state.
    function automatic state_t ref_state(state_t s, logic m, state_t k);
        logic [7:0] coef [4];
        logic [7:0] a    [4];
        logic [7:0] r;
        state_t     res;
        if (m) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < VEC; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[c][31-8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i + 4) % 4], a[j]);
                res[c][31-8*i -: 8] = r;
            end
        end
        return res ^ k;
    endfunction

    task automatic chk_bit(string name, int d, logic act, logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, d, cyc, act, req);
        end
    endtask

    task automatic chk_int(string name, int d, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, req);
        end
    endtask

    task automatic chk_vec(string name, int d, state_t act, state_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, req);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the next edge.
    task automatic monitor();
        cyc++;
        for (int d = 0; d < 2; d++) begin
            int age;
            bit e_ov;
            bit e_busy;
            age = cyc - acc[d];
            if (!rst_n) begin
                chk_bit("rst_in_ready", d, rdy[d], 1'b1);
                chk_bit("rst_out_valid", d, ovl[d], 1'b0);
                chk_bit("rst_busy", d, bsy[d], 1'b0);
                chk_vec("rst_new_vect", d, nv[d], '0);
                inflight[d] = 1'b0;
            end else begin
                e_ov   = inflight[d] && (age > lat_of(d));
                e_busy = inflight[d] && (age <= lat_of(d));
                chk_bit("in_ready", d, rdy[d], !inflight[d]);
                chk_bit("busy", d, bsy[d], e_busy);
                chk_bit("out_valid", d, ovl[d], e_ov);
                if (e_ov) chk_vec("new_vect", d, nv[d], exp_v[d]);
                if (e_ov && out_ready) begin
                    inflight[d] = 1'b0;
                end else if (!inflight[d] && in_valid) begin
                    inflight[d] = 1'b1;
                    acc[d]      = cyc;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
                    exp_v[d]    = ref_state(vect, inv, round_key);
`else
                    exp_v[d]    = ref_state(vect, inv, '0);
`endif
                end
            end
        end
    endtask

    // One clock: compare on the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Present a state once both engines are idle; scramble inputs after acceptance.
    task automatic send(state_t v, logic m);
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 50) begin
            step();
            n++;
        end
        chk_bit("send_idle", 0, rdy[0] && rdy[1], 1'b1);
        vect     = v;
        inv      = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vect     = {$urandom, $urandom, $urandom, $urandom};
        inv      = ~m;
    endtask

    // Wait (bounded) for both engines to finish; check latency in cycles.
    task automatic wait_done();
        int la = -1;
        int lb = -1;
        for (int k = 1; k <= 20 && (la < 0 || lb < 0); k++) begin
            step();
            if (la < 0 && ovl[0]) la = k;
            if (lb < 0 && ovl[1]) lb = k;
        end
        chk_int("latency", 0, la, 4);
        chk_int("latency", 1, lb, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    state_t v1, e1, va, ea, vi, ei, rt, vr;

    initial begin
        in_valid  = 1'b0;
        inv       = 1'b0;
        out_ready = 1'b0;
        vect      = '0;
`ifdef MIX_COLUMNS_ROUNDKEY_EN
        round_key = '0;
`endif
        inflight[0] = 1'b0; inflight[1] = 1'b0;
        acc[0] = 0; acc[1] = 0;
        exp_v[0] = '0; exp_v[1] = '0;

        v1[0] = 32'h637BC0D2; v1[1] = 32'h7B76D27C; v1[2] = 32'h76757CC5; v1[3] = 32'h7563C5C0;
        e1[0] = 32'h591CEEA1; e1[1] = 32'hC28636D1; e1[2] = 32'hCADDAF02; e1[3] = 32'h4A27DCA2;
        va[0] = 32'hdb135345; va[1] = 32'hf20a225c; va[2] = 32'h01010101; va[3] = 32'hc6c6c6c6;
        ea[0] = 32'h8e4da1bc; ea[1] = 32'h9fdc589d; ea[2] = 32'h01010101; ea[3] = 32'hc6c6c6c6;
        vi[0] = 32'h8e4da1bc; vi[1] = 32'h9fdc589d; vi[2] = 32'hd5d5d7d6; vi[3] = 32'h4d7ebdf8;
        ei[0] = 32'hdb135345; ei[1] = 32'hf20a225c; ei[2] = 32'hd4d4d4d5; ei[3] = 32'h2d26314c;

        // Pin the reference model to hand-computed vectors.
        chk_vec("model_fwd", 0, ref_state(v1, 1'b0, '0), e1);
        chk_vec("model_inv", 0, ref_state(vi, 1'b1, '0), ei);

        // Reset.
        #2 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Forward, case-1 vector, then backpressure with a competing request.
        send(v1, 1'b0);
        wait_done();
        chk_vec("fwd_case1", 0, nv[0], e1);
        chk_vec("fwd_case1", 1, nv[1], e1);
        in_valid = 1'b1;
        vect     = va;
        repeat (5) begin
            step();
            chk_bit("bp_out_valid", 0, ovl[0], 1'b1);
            chk_bit("bp_in_ready", 0, rdy[0], 1'b0);
            chk_vec("bp_hold", 0, nv[0], e1);
        end
        in_valid = 1'b0;
        release_out();
        chk_bit("bp_release_ready", 0, rdy[0], 1'b1);
        chk_bit("bp_release_ready", 1, rdy[1], 1'b1);
        chk_bit("bp_release_valid", 0, ovl[0], 1'b0);

        // Forward: mixed columns and all-equal columns.
        send(va, 1'b0);
        wait_done();
        chk_vec("fwd_mixed", 1, nv[1], ea);
        chk_vec("fwd_mixed", 0, nv[0], ea);
        release_out();
        send({4{32'hdb135345}}, 1'b0);
        wait_done();
        chk_vec("fwd_db", 1, nv[1], {4{32'h8e4da1bc}});
        release_out();

        // Inverse literal vector.
        send(vi, 1'b1);
        wait_done();
        chk_vec("inv_lit", 0, nv[0], ei);
        chk_vec("inv_lit", 1, nv[1], ei);
        release_out();

        // Forward then inverse returns the original state.
        send(v1, 1'b0);
        wait_done();
        rt = nv[0];
        release_out();
        send(rt, 1'b1);
        wait_done();
        chk_vec("round_trip", 0, nv[0], v1);
        release_out();

        // Reset two cycles into BUSY aborts everything immediately.
        send(v1, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_bit("abort_out_valid", d, ovl[d], 1'b0);
            chk_bit("abort_busy", d, bsy[d], 1'b0);
            chk_bit("abort_in_ready", d, rdy[d], 1'b1);
            chk_vec("abort_new_vect", d, nv[d], '0);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        vr = {$urandom, $urandom, $urandom, $urandom};
        send(vr, 1'b1);
        wait_done();
        chk_vec("post_reset", 0, nv[0], ref_state(vr, 1'b1, '0));
        release_out();
        send(v1, 1'b0);
        wait_done();
        chk_vec("post_reset_case1", 0, nv[0], e1);
        release_out();

`ifdef MIX_COLUMNS_ROUNDKEY_EN
        // Fused AddRoundKey with an all-ones key.
        round_key = {4{32'hFFFFFFFF}};
        send(v1, 1'b0);
        round_key = '0;
        wait_done();
        chk_vec("roundkey", 0, nv[0],
                {32'hB5D8235D, 32'h352250FD, 32'h3D79C92E, 32'hA6E3115E});
        chk_vec("roundkey", 1, nv[1],
                {32'hB5D8235D, 32'h352250FD, 32'h3D79C92E, 32'hA6E3115E});
        release_out();
`endif

        // Random traffic with random backpressure; the monitor checks every cycle.
        for (int t = 0; t < 800; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            inv       = 1'($urandom_range(0, 1));
            vect      = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MIX_COLUMNS_ROUNDKEY_EN
            round_key = {$urandom, $urandom, $urandom, $urandom};
`endif
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
Name: mix_columns_iter

Overview:
- Sequential, parametrised AES MixColumns engine for the SIMD datapath.
- Accepts a full state of vecSize 32-bit columns through a valid/ready handshake.
- Runs forward or inverse MixColumns, LANES columns per cycle, then holds the result until the consumer takes it.
- Sits between the ShiftRows stage and the AddRoundKey stage of the vector AES pipeline.

Parameters:
- regSize, 32, column width in bits; must be 32 (4 bytes); elaboration error otherwise.
- vecSize, 4, number of columns per state.
- LANES, 1, columns transformed per cycle; must divide vecSize; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input state presented.
- in_ready  out  1  engine can accept a state.
- inv  in  1  mode, sampled with the input: 0 forward MixColumns, 1 InvMixColumns.
- vect  in  [vecSize-1:0][regSize-1:0]  input state, one column per element.
- out_valid  out  1  new_vect holds a finished state.
- out_ready  in  1  consumer accepts the result.
- new_vect  out  [vecSize-1:0][regSize-1:0]  transformed state.
- busy  out  1  high while in the BUSY state.

Behaviour:
- Byte order: byte [31:24] is row 0 and [7:0] is row 3 of each column.
- GF(2^8) arithmetic uses polynomial 0x11B.
- Forward matrix rows: {2,3,1,1} rotated per row. Inverse matrix rows: {0e,0b,0d,09} rotated per row.
- Reset (async assert): state IDLE; in_ready=1; out_valid=0; busy=0; new_vect=0; column index idx=0; latched mode=0. Deassertion is synchronised by the surrounding design.
- FSM:
  - IDLE: in_ready=1. When in_valid&&in_ready, latch vect and inv into the working buffer, set idx=0, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, transform columns idx..idx+LANES-1 in place; idx += LANES. When the last group is written (idx+LANES==vecSize), set idx=0 and go to DONE.
  - DONE: out_valid=1; new_vect = working buffer, held stable. When out_ready, go to IDLE next cycle.
- Latency: out_valid rises exactly vecSize/LANES cycles after the accepting edge. With defaults this is 4 cycles for LANES=1 and 1 cycle for LANES=4.
- Throughput: one state per vecSize/LANES+2 cycles when out_ready is held high.
- in_ready is 0 in BUSY and DONE. in_valid is ignored there, and the working buffer and mode cannot change.
- out_ready while out_valid=0 has no effect.
- inv or vect changing after acceptance has no effect on the in-flight state.
- new_vect keeps its last value in IDLE; it is only meaningful while out_valid=1.
- Reset asserted mid-BUSY or mid-DONE aborts immediately: the state is discarded and all outputs return to their reset values.

Optional Feature:
- Macro: MIX_COLUMNS_ROUNDKEY_EN.
- When defined:
  - Extra input round_key [vecSize-1:0][regSize-1:0] is sampled with vect on acceptance.
  - Each transformed column is XORed with its round_key column in the same cycle it is written (fused AddRoundKey).
  - Latency is unchanged.
- When undefined: the port is absent and the output is pure MixColumns or InvMixColumns.

Test Plan:
- Forward, LANES=1: vect = {637BC0D2, 7B76D27C, 76757CC5, 7563C5C0} (elements 0..3), inv=0. Required: new_vect = {591CEEA1, C28636D1, CADDAF02, 4A27DCA2}; out_valid rises 4 cycles after acceptance.
- Forward, LANES=4, all columns db135345: new_vect all 8e4da1bc; out_valid 1 cycle after acceptance. Also check columns f20a225c -> 9fdc589d, 01010101 -> 01010101, c6c6c6c6 -> c6c6c6c6.
- Inverse, inv=1: columns {8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8} -> {db135345, f20a225c, d4d4d4d5, 2d26314c}. Separately, a forward run followed by an inverse run on the case-1 vector returns the original vect.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: new_vect stable, out_valid held high, in_ready=0, a new in_valid not accepted. Release out_ready: IDLE on the next cycle, in_ready=1.
- Reset mid-BUSY: assert rst_n=0 two cycles after acceptance (LANES=1). Required: immediately out_valid=0, busy=0, in_ready=1, new_vect=0. After release, a fresh state processes correctly with no residue.
- With MIX_COLUMNS_ROUNDKEY_EN: case-1 vector with round_key all FFFFFFFF. Required: new_vect = {A6E3115E, 3D79C92E, 352250FD, B5D8235D}.
